// File: rtl/ex_mem_stage_pkg.sv
// Shared EX/MEM definitions: datapath widths, control-bit bundle, payload layout
// and the state encoding used by the stage's skid buffer.
package ex_mem_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } exmem_ctrl_t;

  typedef struct packed {
    logic                  branch_taken;
    exmem_ctrl_t           ctrl;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  zero;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     store_data;
    logic [DATA_W-1:0]     branch_target;
  } exmem_payload_t;

  localparam int PAYLOAD_W = $bits(exmem_payload_t);

  // Bits that must read 0 whenever the stage holds no entry: all control, never data.
  function automatic exmem_payload_t ctrl_clear_mask();
    exmem_payload_t mask;
    mask              = '0;
    mask.branch_taken = 1'b1;
    mask.ctrl         = '1;
    return mask;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM bus: upstream valid/ready with ALU payload, downstream valid/ready with
// the registered copies. master drives the stage, slave is the stage itself.
interface ex_mem_stage_if;
  import ex_mem_stage_pkg::*;

  logic                  Flush;
  logic                  InValid;
  logic                  InReady;
  logic [DATA_W-1:0]     ALUResult;
  logic                  Zero;
  logic [DATA_W-1:0]     StoreData;
  logic [DATA_W-1:0]     BranchTarget;
  logic [REG_ADDR_W-1:0] WriteReg;
  logic                  RegWrite;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  MemToReg;
  logic                  Branch;

  logic                  OutValid;
  logic                  OutReady;
  logic [DATA_W-1:0]     ALUResult_o;
  logic                  Zero_o;
  logic [DATA_W-1:0]     StoreData_o;
  logic [DATA_W-1:0]     BranchTarget_o;
  logic [REG_ADDR_W-1:0] WriteReg_o;
  logic                  RegWrite_o;
  logic                  MemRead_o;
  logic                  MemWrite_o;
  logic                  MemToReg_o;
  logic                  Branch_o;
  logic                  BranchTaken_o;

  modport master (
    output Flush, InValid, ALUResult, Zero, StoreData, BranchTarget, WriteReg,
           RegWrite, MemRead, MemWrite, MemToReg, Branch, OutReady,
    input  InReady, OutValid, ALUResult_o, Zero_o, StoreData_o, BranchTarget_o,
           WriteReg_o, RegWrite_o, MemRead_o, MemWrite_o, MemToReg_o, Branch_o,
           BranchTaken_o
  );

  modport slave (
    input  Flush, InValid, ALUResult, Zero, StoreData, BranchTarget, WriteReg,
           RegWrite, MemRead, MemWrite, MemToReg, Branch, OutReady,
    output InReady, OutValid, ALUResult_o, Zero_o, StoreData_o, BranchTarget_o,
           WriteReg_o, RegWrite_o, MemRead_o, MemWrite_o, MemToReg_o, Branch_o,
           BranchTaken_o
  );

endinterface

// File: rtl/ex_mem_stage_skid_buf.sv
// Generic 2-entry valid/ready register with a skid slot so in_ready_o comes straight
// from a flop. CLR_MASK bits of the output register are zeroed whenever it empties.
module ex_mem_stage_skid_buf
  import ex_mem_stage_pkg::*;
#(
  parameter int           W        = 8,
  parameter logic [W-1:0] CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire, out_fire;

  assign in_ready_o  = (state_q != ST_SKID);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = out_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no branch can infer a latch.
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      out_d   = out_q & ~CLR_MASK;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            out_d   = in_data_i;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            out_d = in_data_i;
          end else if (in_fire) begin
            skid_d  = in_data_i;
            state_d = ST_SKID;
          end else if (out_fire) begin
            out_d   = out_q & ~CLR_MASK;
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            out_d   = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the data registers are reset too, because every output must read 0 during reset.
    if (rst) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking so all three registers update from the same pre-edge values.
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: packs ALU results and control into a skid-buffered
// payload and resolves the branch decision (Branch & Zero) at load time.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset,
  ex_mem_stage_if.slave  bus
);

  localparam exmem_payload_t CLR_MASK = ctrl_clear_mask();

  exmem_payload_t in_pl;
  exmem_payload_t out_pl;

  always_comb begin
    in_pl                 = '0;
    in_pl.branch_taken    = bus.Branch & bus.Zero;
    in_pl.ctrl.reg_write  = bus.RegWrite;
    in_pl.ctrl.mem_read   = bus.MemRead;
    in_pl.ctrl.mem_write  = bus.MemWrite;
    in_pl.ctrl.mem_to_reg = bus.MemToReg;
    in_pl.ctrl.branch     = bus.Branch;
    in_pl.write_reg       = bus.WriteReg;
    in_pl.zero            = bus.Zero;
    in_pl.alu_result      = bus.ALUResult;
    in_pl.store_data      = bus.StoreData;
    in_pl.branch_target   = bus.BranchTarget;
  end

  ex_mem_stage_skid_buf #(
    .W        (PAYLOAD_W),
    .CLR_MASK (CLR_MASK)
  ) u_skid (
    .clk         (Clk),
    .rst         (Reset),
    .flush_i     (bus.Flush),
    .in_valid_i  (bus.InValid),
    .in_ready_o  (bus.InReady),
    .in_data_i   (in_pl),
    .out_valid_o (bus.OutValid),
    .out_ready_i (bus.OutReady),
    .out_data_o  (out_pl)
  );

  // Control bits are cleared inside the buffer on every empty transition, so they are already qualified.
  assign bus.ALUResult_o    = out_pl.alu_result;
  assign bus.Zero_o         = out_pl.zero;
  assign bus.StoreData_o    = out_pl.store_data;
  assign bus.BranchTarget_o = out_pl.branch_target;
  assign bus.WriteReg_o     = out_pl.write_reg;
  assign bus.RegWrite_o     = out_pl.ctrl.reg_write;
  assign bus.MemRead_o      = out_pl.ctrl.mem_read;
  assign bus.MemWrite_o     = out_pl.ctrl.mem_write;
  assign bus.MemToReg_o     = out_pl.ctrl.mem_to_reg;
  assign bus.Branch_o       = out_pl.ctrl.branch;
  assign bus.BranchTaken_o  = out_pl.branch_taken;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the driver keeps an occupancy model and queues
// expected entries; an independent monitor pops and compares on every output transfer.
`timescale 1ns/1ps
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  ex_mem_stage_if bus();

  ex_mem_stage dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  exmem_payload_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int occ      = 0;
  exmem_payload_t cur;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ctrl = {RegWrite, MemRead, MemWrite, MemToReg, Branch}
  function automatic exmem_payload_t mk(input logic [31:0] alu, input logic zero,
                                        input logic [4:0] ctrl, input logic [31:0] sd,
                                        input logic [31:0] bt, input logic [4:0] wr);
    exmem_payload_t p;
    p.ctrl          = ctrl;
    p.alu_result    = alu;
    p.zero          = zero;
    p.store_data    = sd;
    p.branch_target = bt;
    p.write_reg     = wr;
    p.branch_taken  = ctrl[0] & zero;
    return p;
  endfunction

  function automatic exmem_payload_t observed();
    exmem_payload_t p;
    p.branch_taken    = bus.BranchTaken_o;
    p.ctrl.reg_write  = bus.RegWrite_o;
    p.ctrl.mem_read   = bus.MemRead_o;
    p.ctrl.mem_write  = bus.MemWrite_o;
    p.ctrl.mem_to_reg = bus.MemToReg_o;
    p.ctrl.branch     = bus.Branch_o;
    p.write_reg       = bus.WriteReg_o;
    p.zero            = bus.Zero_o;
    p.alu_result      = bus.ALUResult_o;
    p.store_data      = bus.StoreData_o;
    p.branch_target   = bus.BranchTarget_o;
    return p;
  endfunction

  task automatic drive(input exmem_payload_t p);
    cur              = p;
    bus.ALUResult    = p.alu_result;
    bus.Zero         = p.zero;
    bus.StoreData    = p.store_data;
    bus.BranchTarget = p.branch_target;
    bus.WriteReg     = p.write_reg;
    bus.RegWrite     = p.ctrl.reg_write;
    bus.MemRead      = p.ctrl.mem_read;
    bus.MemWrite     = p.ctrl.mem_write;
    bus.MemToReg     = p.ctrl.mem_to_reg;
    bus.Branch       = p.ctrl.branch;
  endtask

  // One clock: check handshake against the occupancy model, account transfers, advance.
  task automatic step(output bit acc);
    bit in_f, out_f;
    @(negedge Clk);
    check("in_ready",  128'(bus.InReady),  128'(occ != 2));
    check("out_valid", 128'(bus.OutValid), 128'(occ != 0));
    in_f  = bus.InValid && (occ != 2) && !bus.Flush;
    out_f = (occ != 0) && bus.OutReady && !bus.Flush;
    if (bus.Flush) begin
      exp_q.delete();
      occ = 0;
    end else begin
      if (in_f) exp_q.push_back(cur);
      occ = occ + int'(in_f) - int'(out_f);
    end
    acc = in_f;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    bus.InValid = 1'b0;
    repeat (n) step(a);
  endtask

  task automatic send(input exmem_payload_t p);
    bit a;
    int tries;
    drive(p);
    bus.InValid = 1'b1;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 50) begin
      step(a);
      tries++;
    end
    bus.InValid = 1'b0;
    if (!a) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: entry %0h not accepted, required within 50 cycles", p.alu_result);
    end
  endtask

  // Monitor: every output transfer must match the oldest outstanding entry.
  initial begin
    exmem_payload_t e;
    forever begin
      @(negedge Clk);
      if (!Reset && bus.OutValid && bus.OutReady && !bus.Flush) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got entry %0h, required no output", bus.ALUResult_o);
        end else begin
          e = exp_q.pop_front();
          check("out_entry", 128'(observed()), 128'(e));
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, required completion before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    bus.Flush    = 1'b0;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    drive(mk(32'h0, 1'b0, 5'b00000, 32'h0, 32'h0, 5'h0));

    // Reset values
    #1;
    check("rst_out_valid", 128'(bus.OutValid),      128'(0));
    check("rst_alu",       128'(bus.ALUResult_o),   128'(0));
    check("rst_btaken",    128'(bus.BranchTaken_o), 128'(0));
    check("rst_regwrite",  128'(bus.RegWrite_o),    128'(0));
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_in_ready", 128'(bus.InReady), 128'(1));

    // Single entry, one-cycle latency, then drain clears control but holds data
    bus.OutReady = 1'b1;
    send(mk(32'h5, 1'b0, 5'b10000, 32'h0, 32'h0, 5'd3));
    check("t1_out_valid", 128'(bus.OutValid),    128'(1));
    check("t1_alu",       128'(bus.ALUResult_o), 128'(32'h5));
    check("t1_regwrite",  128'(bus.RegWrite_o),  128'(1));
    check("t1_in_ready",  128'(bus.InReady),     128'(1));
    idle(1);
    check("t1_drain_valid", 128'(bus.OutValid),    128'(0));
    check("t1_drain_rw",    128'(bus.RegWrite_o),  128'(0));
    check("t1_drain_alu",   128'(bus.ALUResult_o), 128'(32'h5));

    // Back-pressure into the skid slot, then release
    bus.OutReady = 1'b0;
    send(mk(32'h1, 1'b0, 5'b10000, 32'h0, 32'h0, 5'd1));
    send(mk(32'h2, 1'b0, 5'b10000, 32'h0, 32'h0, 5'd2));
    check("t2_in_ready", 128'(bus.InReady),     128'(0));
    check("t2_head",     128'(bus.ALUResult_o), 128'(32'h1));
    drive(mk(32'h3, 1'b0, 5'b10000, 32'h0, 32'h0, 5'd3));
    bus.InValid = 1'b1;
    step(a);
    check("t2_held",     128'(bus.ALUResult_o), 128'(32'h1));
    check("t2_held_vld", 128'(bus.OutValid),    128'(1));
    bus.OutReady = 1'b1;
    send(mk(32'h3, 1'b0, 5'b10000, 32'h0, 32'h0, 5'd3));
    send(mk(32'h4, 1'b0, 5'b10000, 32'h0, 32'h0, 5'd4));
    idle(3);

    // Branch resolution
    send(mk(32'h0, 1'b1, 5'b00001, 32'h0, 32'h40, 5'd0));
    check("t3_taken",  128'(bus.BranchTaken_o),  128'(1));
    check("t3_target", 128'(bus.BranchTarget_o), 128'(32'h40));
    send(mk(32'h0, 1'b0, 5'b00001, 32'h0, 32'h40, 5'd0));
    check("t3_not_taken", 128'(bus.BranchTaken_o), 128'(0));
    check("t3_branch_o",  128'(bus.Branch_o),      128'(1));
    idle(2);

    // Flush from SKID with a new entry offered in the same cycle
    bus.OutReady = 1'b0;
    send(mk(32'hA, 1'b0, 5'b00100, 32'h1111, 32'h0, 5'd0));
    send(mk(32'hB, 1'b0, 5'b00100, 32'h2222, 32'h0, 5'd0));
    check("t4_skid_ready", 128'(bus.InReady), 128'(0));
    drive(mk(32'hC, 1'b0, 5'b10100, 32'h3333, 32'h0, 5'd7));
    bus.InValid = 1'b1;
    bus.Flush   = 1'b1;
    step(a);
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    check("t4_valid",    128'(bus.OutValid),    128'(0));
    check("t4_memwrite", 128'(bus.MemWrite_o),  128'(0));
    check("t4_in_ready", 128'(bus.InReady),     128'(1));
    check("t4_data_hold", 128'(bus.ALUResult_o), 128'(32'hA));
    bus.OutReady = 1'b1;
    idle(3);

    // Asynchronous reset mid-cycle while FULL
    bus.OutReady = 1'b0;
    send(mk(32'h77, 1'b1, 5'b10001, 32'h55, 32'h80, 5'd9));
    #2 Reset = 1'b1;
    #1;
    check("t5_valid",  128'(bus.OutValid),      128'(0));
    check("t5_btaken", 128'(bus.BranchTaken_o), 128'(0));
    check("t5_alu",    128'(bus.ALUResult_o),   128'(0));
    check("t5_target", 128'(bus.BranchTarget_o), 128'(0));
    check("t5_rw",     128'(bus.RegWrite_o),    128'(0));
    exp_q.delete();
    occ = 0;
    @(posedge Clk);
    #1 Reset = 1'b0;
    bus.OutReady = 1'b1;

    // Random traffic against the scoreboard and occupancy model
    for (int i = 0; i < 10000; i++) begin
      drive(mk($urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               $urandom, $urandom, 5'($urandom_range(0, 31))));
      bus.InValid  = 1'($urandom_range(0, 1));
      bus.OutReady = ($urandom_range(0, 3) != 0);
      bus.Flush    = ($urandom_range(0, 63) == 0);
      step(a);
    end
    bus.Flush    = 1'b0;
    bus.OutReady = 1'b1;
    idle(4);
    check("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
